sr_pulse_sequencer: RTL

SR_PULSE_SEQUENCER -- requirements
Module: sr_pulse_sequencer

---
 rtl/sr_seq_pkg.sv | 35 +++
 rtl/sr_debounce.sv | 90 +++++++++
 rtl/sr_pulse_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sr_seq_pkg.sv
// ---------------------------------------------------------------------------
// sr_seq_pkg
//
// Purpose:
//   Shared definitions for the SR pulse sequencer slice: the sequencer FSM
//   state encoding, the common counter width and a saturating increment
//   helper used by the optional conflict counter.
//
// Contents:
//   CNT_W        width of every cycle counter (debounce, holdoff, conflicts)
//   seq_state_e  sequencer states IDLE / PULSE / HOLDOFF
//   sat_inc()    increment that sticks at the all-ones value
// ---------------------------------------------------------------------------
package sr_seq_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } seq_state_e;

  // Saturating increment: a counter that has reached its maximum stays there
  // instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    result = value;
    if (value != {CNT_W{1'b1}}) begin
      result = value + 1'b1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// ---------------------------------------------------------------------------
// sr_debounce
//
// Purpose:
//   Conditions one asynchronous request line (button or slow control line).
//   The raw level is brought into the clock domain by a two-flop
//   synchronizer, then filtered: the accepted (debounced) level only follows
//   the synchronized level once the two have disagreed for DEBOUNCE_CYCLES
//   consecutive cycles. A single cycle of agreement restarts the count.
//   A one-cycle pulse marks every rising edge of the accepted level; falling
//   edges are not reported.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles needed to accept a new
//                    level (1..255)
//
// Ports:
//   clk     input   clock, all state changes on the rising edge
//   rst     input   asynchronous active-high reset
//   raw_i   input   unsynchronized request level
//   rise_o  output  high for one cycle after the accepted level goes 0 -> 1
// ---------------------------------------------------------------------------
module sr_debounce
  import sr_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic rise_o
);

  // The count compares against the last disagreeing cycle, so the level
  // flips on the same edge that would have made the count reach
  // DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             levelPrev_q;
  logic [CNT_W-1:0] stableCnt_q;
  logic [CNT_W-1:0] stableCnt_d;

  // Two-flop synchronizer. Only sync2_q is allowed to feed any logic; sync1_q
  // may go metastable and is given a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce decision. While the synchronized level agrees with the accepted
  // level the count is held at zero, so any break in a run of disagreement
  // forces the run to start over from scratch.
  always_comb begin
    level_d     = level_q;
    stableCnt_d = '0;
    if (sync2_q != level_q) begin
      if (stableCnt_q == DB_LAST) begin
        level_d = sync2_q;
      end else begin
        stableCnt_d = stableCnt_q + 1'b1;
      end
    end
  end

  // Accepted level, its one-cycle-old copy for edge detection, and the
  // disagreement run counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q     <= 1'b0;
      levelPrev_q <= 1'b0;
      stableCnt_q <= '0;
    end else begin
      level_q     <= level_d;
      levelPrev_q <= level_q;
      stableCnt_q <= stableCnt_d;
    end
  end

  assign rise_o = level_q & ~levelPrev_q;

endmodule

// File: rtl/sr_pulse_sequencer.sv
// ---------------------------------------------------------------------------
// sr_pulse_sequencer
//
// Purpose:
//   Turns two noisy asynchronous request levels (set and clear) into clean,
//   registered, mutually exclusive one-cycle s/r pulses for a downstream SR
//   flip-flop. Each request is synchronized and debounced; its rising edge
//   latches a pending bit. A small sequencer services pending requests one
//   at a time, forcing an idle holdoff window after every pulse. When both
//   requests are pending at once only the priority winner is issued, the
//   other is dropped and a conflict pulse is raised. q_shadow tracks what
//   the downstream flip-flop should hold.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a request level (1..255)
//   HOLDOFF_CYCLES   idle cycles forced after every pulse (0..255)
//   CLR_PRIORITY     1: clear wins a set/clear conflict, 0: set wins
//
// Optional feature (compile-time macro SR_SEQ_CONFLICT_CNT_EN):
//   When defined, adds output conflict_cnt, a saturating 8-bit count of
//   conflict pulses. When undefined, the port and counter do not exist and
//   everything else behaves the same.
//
// Ports:
//   clk           input   clock, all state changes on the rising edge
//   rst           input   asynchronous active-high reset
//   set_raw       input   asynchronous set request level
//   clr_raw       input   asynchronous clear request level
//   s             output  one-cycle registered set pulse
//   r             output  one-cycle registered reset pulse
//   q_shadow      output  expected state of the downstream flip-flop
//   busy          output  high while a pulse or its holdoff is in progress
//   conflict      output  one-cycle pulse when arbitration drops a request
//   conflict_cnt  output  [7:0] saturating conflict count (macro only)
// ---------------------------------------------------------------------------
module sr_pulse_sequencer
  import sr_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLDOFF_CYCLES  = 2,
  parameter int unsigned CLR_PRIORITY    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_raw,
  input  logic             clr_raw,
  output logic             s,
  output logic             r,
  output logic             q_shadow,
  output logic             busy,
  output logic             conflict
`ifdef SR_SEQ_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  // Value loaded into the holdoff counter on leaving PULSE. The FSM leaves
  // HOLDOFF on the cycle the counter is already zero, so loading N-1 yields
  // exactly N holdoff cycles. With no holdoff the value is never used.
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (HOLDOFF_CYCLES == 0) ? '0 : CNT_W'(HOLDOFF_CYCLES - 1);

  logic             setRise;
  logic             clrRise;

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic             pendSet_q;
  logic             pendSet_d;
  logic             pendClr_q;
  logic             pendClr_d;
  logic [CNT_W-1:0] holdCnt_q;
  logic [CNT_W-1:0] holdCnt_d;
  logic             s_q;
  logic             s_d;
  logic             r_q;
  logic             r_d;
  logic             conflict_q;
  logic             conflict_d;
  logic             qShadow_q;
  logic             qShadow_d;

  sr_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_setDebounce (
    .clk   (clk),
    .rst   (rst),
    .raw_i (set_raw),
    .rise_o(setRise)
  );

  sr_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clrDebounce (
    .clk   (clk),
    .rst   (rst),
    .raw_i (clr_raw),
    .rise_o(clrRise)
  );

  // Sequencer next state and registered pulse outputs.
  // Pending bits accumulate rising edges in every state, so requests that
  // arrive during PULSE or HOLDOFF wait their turn, and a repeat edge while a
  // bit is already pending just merges into it. A bit is only consumed when
  // IDLE launches a pulse; an edge landing on that same cycle is kept rather
  // than lost. s/r/conflict are computed one cycle ahead and registered, so
  // they come straight from flops and line up with the PULSE state.
  always_comb begin
    state_d    = state_q;
    holdCnt_d  = holdCnt_q;
    pendSet_d  = pendSet_q | setRise;
    pendClr_d  = pendClr_q | clrRise;
    s_d        = 1'b0;
    r_d        = 1'b0;
    conflict_d = 1'b0;
    qShadow_d  = qShadow_q;

    if (s_q) begin
      qShadow_d = 1'b1;
    end else if (r_q) begin
      qShadow_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pendSet_q && pendClr_q) begin
          state_d    = PULSE;
          conflict_d = 1'b1;
          pendSet_d  = setRise;
          pendClr_d  = clrRise;
          if (CLR_PRIORITY != 0) begin
            r_d = 1'b1;
          end else begin
            s_d = 1'b1;
          end
        end else if (pendSet_q) begin
          state_d   = PULSE;
          s_d       = 1'b1;
          pendSet_d = setRise;
        end else if (pendClr_q) begin
          state_d   = PULSE;
          r_d       = 1'b1;
          pendClr_d = clrRise;
        end
      end

      PULSE: begin
        if (HOLDOFF_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d   = HOLDOFF;
          holdCnt_d = HOLD_LAST;
        end
      end

      HOLDOFF: begin
        if (holdCnt_q == '0) begin
          state_d = IDLE;
        end else begin
          holdCnt_d = holdCnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state register. Reset drops everything at once, even in the
  // middle of a pulse or holdoff, so no pulse can leak out afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      holdCnt_q  <= '0;
      pendSet_q  <= 1'b0;
      pendClr_q  <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      qShadow_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      holdCnt_q  <= holdCnt_d;
      pendSet_q  <= pendSet_d;
      pendClr_q  <= pendClr_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
      qShadow_q  <= qShadow_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign conflict = conflict_q;
  assign q_shadow = qShadow_q;
  assign busy     = (state_q != IDLE);

`ifdef SR_SEQ_CONFLICT_CNT_EN
  logic [CNT_W-1:0] conflictCnt_q;

  // Conflict counter. It advances on the same edge that raises the conflict
  // pulse, so the count already includes a conflict while it is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflictCnt_q <= '0;
    end else if (conflict_d) begin
      conflictCnt_q <= sat_inc(conflictCnt_q);
    end
  end

  assign conflict_cnt = conflictCnt_q;
`endif

endmodule
